// File: rtl/motor_pwm_ctrl.sv
// ============================================================================
//  Module   : motor_pwm_ctrl
//  Brief    : N-channel H-bridge PWM driver with a shared period counter,
//             double-buffered commands, dead-time on reversal and braking.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module motor_pwm_ctrl #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 14,
    parameter int PERIOD   = 11000,
    parameter int DEAD_CYC = 100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic                      load_i,
    input  logic [NUM_CH*CNT_W-1:0]   speed_i,
    input  logic [NUM_CH-1:0]         dir_i,
    input  logic [NUM_CH-1:0]         brake_i,
    output logic [NUM_CH-1:0]         out_a_o,
    output logic [NUM_CH-1:0]         out_b_o,
    output logic                      period_start_o
);

    localparam int              DW     = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DW-1:0]    C_DEAD = DW'(DEAD_CYC);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DEAD  = 2'd1,
        ST_BRAKE = 2'd2
    } state_t;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CH*CNT_W-1:0] pend_speed_q;
    logic [NUM_CH-1:0]       pend_dir_q, pend_brake_q;
    logic                    period_start_q;
    logic                    wrap;

    assign wrap = en_i && (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en_i || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            pend_speed_q   <= '0;
            pend_dir_q     <= '0;
            pend_brake_q   <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= en_i && (cnt_q == '0);
            if (load_i) begin
                pend_speed_q <= speed_i;
                pend_dir_q   <= dir_i;
                pend_brake_q <= brake_i;
            end
        end
    end

    assign period_start_o = period_start_q;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] act_speed_q;
            logic             act_dir_q, last_dir_q;
            logic             out_a_q, out_b_q;
            logic [DW-1:0]    dead_q;
            state_t           state_q;
            logic [CNT_W-1:0] new_speed;
            logic             new_dir, new_brake, pwm;

            // A load coinciding with the wrap edge bypasses the pending stage.
            assign new_speed = load_i ? speed_i[i*CNT_W +: CNT_W] : pend_speed_q[i*CNT_W +: CNT_W];
            assign new_dir   = load_i ? dir_i[i]   : pend_dir_q[i];
            assign new_brake = load_i ? brake_i[i] : pend_brake_q[i];
            assign pwm       = cnt_q < act_speed_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    act_speed_q <= '0;
                    act_dir_q   <= 1'b0;
                    last_dir_q  <= 1'b0;
                    dead_q      <= '0;
                    state_q     <= ST_RUN;
                    out_a_q     <= 1'b0;
                    out_b_q     <= 1'b0;
                end else if (!en_i) begin
                    act_speed_q <= new_speed;
                    act_dir_q   <= new_dir;
                    last_dir_q  <= new_dir;
                    dead_q      <= '0;
                    state_q     <= ST_RUN;
                    out_a_q     <= 1'b0;
                    out_b_q     <= 1'b0;
                end else begin
                    case (state_q)
                        ST_RUN: begin
                            out_a_q <= act_dir_q & pwm;
                            out_b_q <= ~act_dir_q & pwm;
                        end
                        ST_BRAKE: begin
                            out_a_q <= 1'b1;
                            out_b_q <= 1'b1;
                        end
                        default: begin
                            out_a_q <= 1'b0;
                            out_b_q <= 1'b0;
                        end
                    endcase

                    if (wrap) begin
                        act_speed_q <= new_speed;
                        act_dir_q   <= new_dir;
                        if (new_brake) begin
                            state_q <= ST_BRAKE;
                            dead_q  <= '0;
                        end else if ((new_dir != last_dir_q) && (DEAD_CYC > 0)) begin
                            state_q <= ST_DEAD;
                            dead_q  <= C_DEAD;
                        end else begin
                            state_q    <= ST_RUN;
                            last_dir_q <= new_dir;
                            dead_q     <= '0;
                        end
                    end else if (state_q == ST_DEAD) begin
                        // Leaving on the last dead cycle lets the next output follow pwm.
                        if (dead_q <= DW'(1)) begin
                            state_q    <= ST_RUN;
                            last_dir_q <= act_dir_q;
                            dead_q     <= '0;
                        end else begin
                            dead_q <= dead_q - DW'(1);
                        end
                    end
                end
            end

            assign out_a_o[i] = out_a_q;
            assign out_b_o[i] = out_b_q;
        end
    endgenerate

endmodule

`default_nettype wire
